div_wb_buffer: RTL and testbench

DIV_WB_BUFFER -- requirements
Module: div_wb_buffer

---
 rtl/div_pkg.sv | 10 +
 rtl/div_wb_fifo.sv | 49 ++++
 rtl/div_wb_buffer.sv | 64 ++++++
 tb/tb_div_wb_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths and writeback entry type for the divider result path
package div_pkg;
  localparam int DIV_TAG_W  = 8;
  localparam int DIV_DATA_W = 32;
  typedef struct packed {
    logic [DIV_DATA_W-1:0] result;
    logic [DIV_TAG_W-1:0]  tag;
    logic [DIV_DATA_W-1:0] pc;
  } div_wb_entry_t;
endpackage

// File: rtl/div_wb_fifo.sv
// div_wb_fifo: synchronous result FIFO; a push into a full FIFO lands only when a pop frees the slot
module div_wb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 72
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign count   = cnt_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem_q[rd_q];
  // next pointers, count and storage; power-of-two depth makes pointers wrap for free
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // storage needs no reset: the head output is masked while empty
  always_ff @(posedge clk) mem_q <= mem_d;
  // control state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/div_wb_buffer.sv
// div_wb_buffer: credit-managed writeback buffer between divider and CDB (optional checker: DIV_WB_ERR_CHECK_EN)
module div_wb_buffer
  import div_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = DIV_TAG_W,
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    div_start,
  input  logic                    div_done,
  input  logic [DATA_W-1:0]       div_result,
  input  logic [TAG_W-1:0]        div_tag,
  input  logic [DATA_W-1:0]       div_pc,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [DATA_W-1:0]       cdb_result,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_pc,
  output logic                    issue_ok,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * DATA_W + TAG_W;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW:0]   credit;
  logic [EW-1:0] head;
  logic          pop, full, empty;
  assign cdb_valid = ~empty;
  assign pop       = cdb_valid & cdb_ready;
  assign credit    = {1'b0, occupancy} + {1'b0, inflight_q};
  assign issue_ok  = credit < (CW+1)'(DEPTH);
  assign {cdb_result, cdb_tag, cdb_pc} = head;
  div_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk), .reset(reset), .push(div_done), .pop(pop),
    .din({div_result, div_tag, div_pc}), .dout(head),
    .full(full), .empty(empty), .count(occupancy)
  );
  // in-flight divide count, saturating at 0 and DEPTH
  always_comb
    inflight_d = (div_start && !div_done && inflight_q != CW'(DEPTH)) ? inflight_q + CW'(1) :
                 (!div_start && div_done && inflight_q != '0)         ? inflight_q - CW'(1) : inflight_q;
  // in-flight register
  always_ff @(posedge clk or negedge reset)
    if (!reset) inflight_q <= '0;
    else        inflight_q <= inflight_d;
`ifdef DIV_WB_ERR_CHECK_EN
  logic err_q, err_d;
  // sticky: dropped push, issue without credit, or completion with nothing in flight
  always_comb
    err_d = err_q | (div_done & full & ~pop) | (div_start & ~issue_ok) | (div_done & (inflight_q == '0));
  // error flag register
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  assign overflow_err = err_q;
`else
  logic unused_full;
  assign unused_full  = full;
  assign overflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_div_wb_buffer.sv
// tb_div_wb_buffer: scoreboard bench for div_wb_buffer (expects overflow_err only when DIV_WB_ERR_CHECK_EN is defined)
module tb_div_wb_buffer;
  import div_pkg::*;
  logic        clk, reset, div_start, div_done, cdb_valid, cdb_ready, issue_ok, overflow_err;
  logic [31:0] div_result, div_pc, cdb_result, cdb_pc;
  logic [7:0]  div_tag, cdb_tag;
  logic [3:0]  occupancy;
  int          vectors, miscompares;
  int          m_occ, m_inf;
  bit          m_err;
  div_wb_entry_t sb[$];

  div_wb_buffer dut (
    .clk(clk), .reset(reset), .div_start(div_start), .div_done(div_done),
    .div_result(div_result), .div_tag(div_tag), .div_pc(div_pc),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_result(cdb_result),
    .cdb_tag(cdb_tag), .cdb_pc(cdb_pc), .issue_ok(issue_ok),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    m_occ = 0;
    m_inf = 0;
    m_err = 0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    div_start = 0; div_done = 0; cdb_ready = 0;
    div_result = '0; div_tag = '0; div_pc = '0;
  endtask

  // one clock: drive, check at negedge against model, advance model, then cross the posedge
  task automatic step(input logic s, input logic d, input logic [31:0] r, input logic [7:0] t,
                      input logic [31:0] p, input logic rdy);
    bit pop, push;
    div_wb_entry_t e;
    div_start = s; div_done = d; div_result = r; div_tag = t; div_pc = p; cdb_ready = rdy;
    @(negedge clk);
    chk("occupancy", 72'(occupancy), 72'(m_occ));
    chk("cdb_valid", 72'(cdb_valid), 72'(m_occ != 0));
    chk("issue_ok", 72'(issue_ok), 72'((m_occ + m_inf) < 8));
    chk("overflow_err", 72'(overflow_err), 72'(m_err));
    pop = (m_occ != 0) && rdy;
    if (pop) begin
      if (sb.size() == 0) chk("sb_underrun", 72'(1), 72'(0));
      else begin
        e = sb.pop_front();
        chk("cdb_result", 72'(cdb_result), 72'(e.result));
        chk("cdb_tag", 72'(cdb_tag), 72'(e.tag));
        chk("cdb_pc", 72'(cdb_pc), 72'(e.pc));
      end
    end
`ifdef DIV_WB_ERR_CHECK_EN
    if (d && m_occ == 8 && !pop) m_err = 1;
    if (s && (m_occ + m_inf) >= 8) m_err = 1;
    if (d && m_inf == 0) m_err = 1;
`endif
    push = d && (m_occ < 8 || pop);
    if (push) begin
      e.result = r; e.tag = t; e.pc = p;
      sb.push_back(e);
    end
    m_occ = m_occ + int'(push) - int'(pop);
    if (s && !d && m_inf < 8) m_inf++;
    else if (!s && d && m_inf > 0) m_inf--;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_model();
    idle_inputs();
    reset = 0;
    #12;
    chk("rst_cdb_valid", 72'(cdb_valid), 72'(0));
    chk("rst_cdb_result", 72'(cdb_result), 72'(0));
    chk("rst_cdb_tag", 72'(cdb_tag), 72'(0));
    chk("rst_cdb_pc", 72'(cdb_pc), 72'(0));
    chk("rst_occupancy", 72'(occupancy), 72'(0));
    chk("rst_issue_ok", 72'(issue_ok), 72'(1));
    chk("rst_overflow_err", 72'(overflow_err), 72'(0));
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    // single result: one-cycle latency, then popped
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h7, 8'h12, 32'h40, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // eight issues then eight completions with CDB stalled
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h100 + i, 8'(i + 1), 32'h1000 + 4 * i, 0);
    step(0, 0, 0, 0, 0, 0);
    // full FIFO: completion and pop together keep it full and append at tail
    step(0, 1, 32'hBEEF, 8'hAA, 32'h2000, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
    idle_inputs();
    @(negedge clk) reset = 0;
    clear_model();
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    // issue beyond credit
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 32'h300 + i, 8'(i), 32'h3000 + i, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    idle_inputs();
    @(negedge clk) reset = 0;
    clear_model();
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    // randomised traffic within the credit protocol
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(1)) && (m_occ + m_inf) < 8, 1'($urandom_range(1)) && m_inf > 0,
           $urandom, 8'($urandom), $urandom, 1'($urandom_range(1)));
    for (int i = 0; i < 10; i++) step(0, m_inf > 0, $urandom, 8'($urandom), $urandom, 1);
    // async reset mid-operation with occupancy 5, inflight 2
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h500 + i, 8'h50 + 8'(i), 32'h5000 + i, 0);
    step(0, 0, 0, 0, 0, 0);
    idle_inputs();
    #2 reset = 0;
    #1;
    chk("arst_cdb_valid", 72'(cdb_valid), 72'(0));
    chk("arst_occupancy", 72'(occupancy), 72'(0));
    chk("arst_issue_ok", 72'(issue_ok), 72'(1));
    chk("arst_overflow_err", 72'(overflow_err), 72'(0));
    clear_model();
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
